computie_bus_initiator: RTL
===========================

// Module: computie_bus_initiator
// PURPOSE
//  Bus master end of the Computie bus: turns one internal read/write request into a full
//  AS/DS strobe cycle on the multiplexed address/data lines, driving the transceivers toward
//  the bus. Peer of the FPGA bus receivers; lets the FPGA itself access other bus devices.
//  Sits between an internal request port and the bus demux/transceiver pins.
// PARAMETERS
//  BITWIDTH      32  width of address, data, cb_to_bus and cb_from_bus
//  ADDR_CYCLES    2  cycles address is held with AS asserted before DS asserts (min 1)
//  DATA_CYCLES    2  min cycles DS is held before the cycle may complete (min 1)
//  TIMEOUT       64  max cycles in DATA waiting for cb_dtack before bus error
// PORTS
//  cb_clk         in   1         bus clock; all logic on posedge (receivers sample on negedge)
//  cb_reset       in   1         asynchronous, active-high reset
//  req_valid      in   1         request strobe; accepted when req_ready=1
//  req_ready      out  1         high only in IDLE
//  req_write      in   1         1=write to bus device, 0=read from bus device
//  req_addr       in   BITWIDTH  target address
//  req_wdata      in   BITWIDTH  write data
//  resp_valid     out  1         one-cycle pulse at completion
//  resp_error     out  1         valid with resp_valid: 1=timeout
//  resp_rdata     out  BITWIDTH  read data; held until next read completes
//  cb_addr_strobe out  1         active-low AS
//  cb_data_strobe out  1         active-low DS
//  cb_read_write  out  1         1=read, 0=write
//  cb_dtack       in   1         active-low target acknowledge
//  cb_demux_oe    out  1         1=drive cb_to_bus onto the bus
//  cb_to_bus      out  BITWIDTH  address/data driven to bus
//  cb_from_bus    in   BITWIDTH  data read from bus
//  send_receive   out  1         transceiver direction, tied 1 (send)
//  addr_oe, data_oe  out 1       active-low transceiver enables
//  data_dir       out  1         0=toward bus (output), 1=from bus
// BEHAVIOUR
//  Reset (async): state IDLE; AS=DS=1, cb_read_write=1, cb_demux_oe=0, cb_to_bus=0,
//   addr_oe=data_oe=1, data_dir=0, req_ready=1, resp_valid=0, resp_error=0, resp_rdata=0.
//   Reset mid-cycle releases strobes immediately; no resp_valid for the aborted request.
//  IDLE: req_ready=1. req_valid=1 latches write/addr/wdata, -> ADDR. Counter cleared.
//  ADDR: AS=0, cb_to_bus=addr, cb_demux_oe=1, addr_oe=0, data_oe=1, cb_read_write=~write.
//   After ADDR_CYCLES -> STROBE.
//  STROBE (1 cycle): DS=0, AS=0, address still driven so the target sees address+DS together.
//   -> DATA.
//  DATA: AS=0, DS=0, addr_oe=1, data_oe=0. Write: cb_to_bus=wdata, cb_demux_oe=1,
//   data_dir=0. Read: cb_demux_oe=0, data_dir=1 (turnaround). Counter counts DATA cycles.
//   Completes when count>=DATA_CYCLES and cb_dtack=0: read latches cb_from_bus into
//   resp_rdata that edge; -> END. If count reaches TIMEOUT without dtack -> END with error.
//   dtack before DATA_CYCLES is ignored until the minimum is met.
//  END (1 cycle): AS=DS=1, cb_demux_oe=0, both OEs=1, cb_read_write=1; resp_valid=1,
//   resp_error per outcome -> IDLE. Thus min latency req accept->resp_valid =
//   ADDR_CYCLES+DATA_CYCLES+2 cycles; next request accepted the cycle after END.
//  req_valid outside IDLE is ignored (req_ready=0); no queuing.
//  Counter width: $clog2(TIMEOUT+1); saturates, no wrap.
//  Never cb_demux_oe=1 with data_dir=1.
// STRUCTURE
//  Shared package/include (computie_bus_defs): ACTIVE/INACTIVE, DIR_INPUT/DIR_OUTPUT,
//   state encodings, also used by receivers. Single module, no sub-modules; the
//   wait/timeout counter is inline.
// TESTING
//  Write addr=0x00500010 data=0xDEADBEEF, dtack tied 0 -> AS low 2 cycles with addr on bus,
//   DS low, wdata on bus, resp_valid at cycle 6 after accept, resp_error=0.
//  Read addr=0x00500020, model receiver drives 0x12345678 -> resp_rdata=0x12345678,
//   cb_demux_oe=0 throughout DATA, data_dir=1.
//  Read, dtack held 1 -> resp_valid with resp_error=1 after TIMEOUT DATA cycles, strobes high.
//  dtack asserted 5 cycles late -> DS extends exactly 5 cycles, normal completion.
//  Assert reset in DATA of a write -> AS/DS high, demux off same cycle, no resp_valid.
//  Back-to-back requests, req_valid held high -> second accepted cycle after END; ready=0 mid.

Source files
------------

// File: rtl/computie_bus_initiator_pkg.sv
// Computie bus shared definitions: strobe polarity, transceiver
// direction and the initiator's state encoding.
package computie_bus_initiator_pkg;

  localparam logic ACTIVE     = 1'b0;
  localparam logic INACTIVE   = 1'b1;
  localparam logic DIR_OUTPUT = 1'b0;
  localparam logic DIR_INPUT  = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ADDR   = 3'd1,
    ST_STROBE = 3'd2,
    ST_DATA   = 3'd3,
    ST_END    = 3'd4
  } cb_state_e;

endpackage

// File: rtl/computie_bus_initiator_if.sv
// Request/response port plus Computie bus pins of the initiator.
// master = the initiator, slave = requester and bus side.
interface computie_bus_initiator_if #(
  parameter int BITWIDTH = 32
);

  logic                req_valid;
  logic                req_ready;
  logic                req_write;
  logic [BITWIDTH-1:0] req_addr;
  logic [BITWIDTH-1:0] req_wdata;
  logic                resp_valid;
  logic                resp_error;
  logic [BITWIDTH-1:0] resp_rdata;
  logic                cb_addr_strobe;
  logic                cb_data_strobe;
  logic                cb_read_write;
  logic                cb_dtack;
  logic                cb_demux_oe;
  logic [BITWIDTH-1:0] cb_to_bus;
  logic [BITWIDTH-1:0] cb_from_bus;
  logic                send_receive;
  logic                addr_oe;
  logic                data_oe;
  logic                data_dir;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata,
    input  cb_dtack, cb_from_bus,
    output req_ready, resp_valid, resp_error, resp_rdata,
    output cb_addr_strobe, cb_data_strobe, cb_read_write,
    output cb_demux_oe, cb_to_bus, send_receive,
    output addr_oe, data_oe, data_dir
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata,
    output cb_dtack, cb_from_bus,
    input  req_ready, resp_valid, resp_error, resp_rdata,
    input  cb_addr_strobe, cb_data_strobe, cb_read_write,
    input  cb_demux_oe, cb_to_bus, send_receive,
    input  addr_oe, data_oe, data_dir
  );

endinterface

// File: rtl/computie_bus_initiator.sv
// Computie bus master: one internal request becomes one AS/DS
// strobe cycle on the multiplexed address/data lines.
module computie_bus_initiator
  import computie_bus_initiator_pkg::*;
#(
  parameter int BITWIDTH    = 32,
  parameter int ADDR_CYCLES = 2,
  parameter int DATA_CYCLES = 2,
  parameter int TIMEOUT     = 64
) (
  input logic cb_clk,
  input logic cb_reset,
  computie_bus_initiator_if.master bus
);

  localparam int MAX_AD = (ADDR_CYCLES > DATA_CYCLES) ?
                          ADDR_CYCLES : DATA_CYCLES;
  localparam int MAXC   = (TIMEOUT > MAX_AD) ? TIMEOUT : MAX_AD;
  localparam int CW     = $clog2(MAXC + 1);

  localparam logic [CW-1:0] AC_L = CW'(ADDR_CYCLES);
  localparam logic [CW-1:0] DC_L = CW'(DATA_CYCLES);
  localparam logic [CW-1:0] TO_L = CW'(TIMEOUT);

  cb_state_e state_q, state_d;

  logic [CW-1:0]       cnt_q, cnt_d, cnt_inc;
  logic                err_q, err_d;
  logic [BITWIDTH-1:0] rdata_q, rdata_d;
  logic                write_q;
  logic [BITWIDTH-1:0] addr_q;
  logic [BITWIDTH-1:0] wdata_q;

  logic st_idle, st_addr, st_strobe, st_data, st_end;
  logic accept, dtack_seen;

  assign st_idle   = (state_q == ST_IDLE);
  assign st_addr   = (state_q == ST_ADDR);
  assign st_strobe = (state_q == ST_STROBE);
  assign st_data   = (state_q == ST_DATA);
  assign st_end    = (state_q == ST_END);

  assign accept     = st_idle && bus.req_valid;
  assign dtack_seen = (bus.cb_dtack == ACTIVE);

  // Shared ADDR/DATA counter; sticks at all-ones instead of wrapping.
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

  always_ff @(posedge cb_clk or posedge cb_reset) begin
    if (cb_reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge cb_clk or posedge cb_reset) begin
    if (cb_reset) begin
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      write_q <= bus.req_write;
      addr_q  <= bus.req_addr;
      wdata_q <= bus.req_wdata;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (bus.req_valid) state_d = ST_ADDR;
      end
      ST_ADDR: begin
        cnt_d = cnt_inc;
        if (cnt_inc >= AC_L) begin
          state_d = ST_STROBE;
          cnt_d   = '0;
        end
      end
      ST_STROBE: begin
        cnt_d   = '0;
        state_d = ST_DATA;
      end
      ST_DATA: begin
        cnt_d = cnt_inc;
        // An acknowledge wins over a timeout landing on the same cycle.
        if (cnt_inc >= DC_L && dtack_seen) begin
          state_d = ST_END;
          err_d   = 1'b0;
          if (!write_q) rdata_d = bus.cb_from_bus;
        end else if (cnt_inc >= TO_L) begin
          state_d = ST_END;
          err_d   = 1'b1;
        end
      end
      ST_END: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Pins decode from state alone so an async reset drops them at once.
  always_comb begin
    bus.req_ready      = 1'b0;
    bus.resp_valid     = 1'b0;
    bus.cb_addr_strobe = INACTIVE;
    bus.cb_data_strobe = INACTIVE;
    bus.cb_read_write  = 1'b1;
    bus.cb_demux_oe    = 1'b0;
    bus.cb_to_bus      = '0;
    bus.addr_oe        = INACTIVE;
    bus.data_oe        = INACTIVE;
    bus.data_dir       = DIR_OUTPUT;
    unique case (1'b1)
      st_idle: bus.req_ready = 1'b1;
      st_addr, st_strobe: begin
        bus.cb_addr_strobe = ACTIVE;
        bus.cb_data_strobe = st_strobe ? ACTIVE : INACTIVE;
        bus.cb_read_write  = ~write_q;
        bus.cb_demux_oe    = 1'b1;
        bus.cb_to_bus      = addr_q;
        bus.addr_oe        = ACTIVE;
      end
      st_data: begin
        bus.cb_addr_strobe = ACTIVE;
        bus.cb_data_strobe = ACTIVE;
        bus.cb_read_write  = ~write_q;
        bus.data_oe        = ACTIVE;
        if (write_q) begin
          bus.cb_demux_oe = 1'b1;
          bus.cb_to_bus   = wdata_q;
        end else begin
          bus.data_dir = DIR_INPUT;
        end
      end
      st_end: bus.resp_valid = 1'b1;
      default: ;
    endcase
  end

  assign bus.resp_error   = st_end && err_q;
  assign bus.resp_rdata   = rdata_q;
  assign bus.send_receive = 1'b1;

endmodule
